// File: rtl/arith_select_pipe.sv
// Two-stage add/subtract/select/accumulate datapath with valid/ready handshake on both sides.
// Optional debug outputs (stage-1 operands, accumulator, transfer count) are enabled by ARITH_SELECT_PIPE_MONITOR_EN.
module arith_select_pipe #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_s,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
`ifdef ARITH_SELECT_PIPE_MONITOR_EN
  ,
  output logic [WIDTH-1:0] mon_a,
  output logic [WIDTH-1:0] mon_b,
  output logic [WIDTH-1:0] mon_c,
  output logic             mon_s,
  output logic [WIDTH-1:0] mon_acc,
  output logic [15:0]      mon_count
`endif
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SEL = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  logic             s1_valid_r;
  logic [1:0]       s1_op_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [WIDTH-1:0] s1_c_r;
  logic             s1_s_r;
  logic             s1_clr_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_carry_r;
  logic             out_zero_r;
  logic [WIDTH-1:0] acc_r;

  logic             advance_s;
  logic             in_fire_s;
  logic [WIDTH:0]   a_x_s;
  logic [WIDTH:0]   b_x_s;
  logic [WIDTH:0]   c_x_s;
  logic [WIDTH:0]   acc_x_s;
  logic [WIDTH:0]   raw_s;
  logic             carry_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] acc_next_s;

  // Handshake: output stage frees up when empty or drained; stage 1 accepts when empty or moving on.
  always_comb begin
    advance_s = !out_valid_r || out_ready;
    in_ready  = !s1_valid_r || advance_s;
    in_fire_s = in_valid && in_ready;
  end

  // Stage-1 operand capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 2'b00;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_c_r     <= {WIDTH{1'b0}};
      s1_s_r     <= 1'b0;
      s1_clr_r   <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= in_op;
      s1_a_r     <= in_a;
      s1_b_r     <= in_b;
      s1_c_r     <= in_c;
      s1_s_r     <= in_s;
      s1_clr_r   <= in_clr;
    end else if (advance_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage-2 arithmetic at WIDTH+1 bits so the top bit is the carry/borrow.
  always_comb begin
    a_x_s      = {1'b0, s1_a_r};
    b_x_s      = {1'b0, s1_b_r};
    c_x_s      = {1'b0, s1_c_r};
    acc_x_s    = {1'b0, acc_r};
    raw_s      = {(WIDTH+1){1'b0}};
    carry_s    = 1'b0;
    result_s   = {WIDTH{1'b0}};
    acc_next_s = acc_r;
    case (s1_op_r)
      OP_ADD: raw_s = a_x_s + b_x_s;
      OP_SUB: raw_s = a_x_s - c_x_s;
      OP_SEL: begin
        if (s1_s_r) begin
          raw_s = a_x_s - c_x_s;
        end else begin
          raw_s = a_x_s;
        end
      end
      OP_ACC: begin
        if (s1_clr_r) begin
          raw_s = a_x_s;
        end else begin
          raw_s = acc_x_s + a_x_s;
        end
      end
      default: raw_s = {(WIDTH+1){1'b0}};
    endcase
    carry_s = raw_s[WIDTH];
    // Carry on ADD/ACC clamps high, borrow on SUB/SEL clamps low.
    if (SATURATE != 0 && carry_s) begin
      if (s1_op_r == OP_ADD || s1_op_r == OP_ACC) begin
        result_s = {WIDTH{1'b1}};
      end else begin
        result_s = {WIDTH{1'b0}};
      end
    end else begin
      result_s = raw_s[WIDTH-1:0];
    end
    if (s1_op_r == OP_ACC) begin
      acc_next_s = result_s;
    end else if (s1_clr_r) begin
      acc_next_s = {WIDTH{1'b0}};
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Output register and accumulator; both hold while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_carry_r <= 1'b0;
      out_zero_r  <= 1'b1;
      acc_r       <= {WIDTH{1'b0}};
    end else if (advance_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r  <= result_s;
        out_carry_r <= carry_s;
        out_zero_r  <= (result_s == {WIDTH{1'b0}});
        acc_r       <= acc_next_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_carry = out_carry_r;
  assign out_zero  = out_zero_r;

`ifdef ARITH_SELECT_PIPE_MONITOR_EN
  logic [15:0] mon_count_r;

  // Output transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_count_r <= 16'd0;
    end else if (out_valid_r && out_ready) begin
      mon_count_r <= mon_count_r + 16'd1;
    end
  end

  assign mon_a     = s1_a_r;
  assign mon_b     = s1_b_r;
  assign mon_c     = s1_c_r;
  assign mon_s     = s1_s_r;
  assign mon_acc   = acc_r;
  assign mon_count = mon_count_r;
`endif

endmodule

// File: tb/tb_arith_select_pipe.sv
// Scoreboard bench for arith_select_pipe: one wrapping and one saturating instance share stimulus.
module tb_arith_select_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b, in_c;
  logic         in_s, in_clr;
  logic         out_ready;

  logic         in_ready0, out_valid0, out_carry0, out_zero0;
  logic [W-1:0] out_data0;
  logic         in_ready1, out_valid1, out_carry1, out_zero1;
  logic [W-1:0] out_data1;

`ifdef ARITH_SELECT_PIPE_MONITOR_EN
  logic [W-1:0] mon_a0, mon_b0, mon_c0, mon_acc0, mon_a1, mon_b1, mon_c1, mon_acc1;
  logic         mon_s0, mon_s1;
  logic [15:0]  mon_count0, mon_count1;
`endif

  always #5 clk = ~clk;

  arith_select_pipe #(.WIDTH(W), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_s(in_s), .in_clr(in_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_carry(out_carry0), .out_zero(out_zero0)
`ifdef ARITH_SELECT_PIPE_MONITOR_EN
    , .mon_a(mon_a0), .mon_b(mon_b0), .mon_c(mon_c0), .mon_s(mon_s0),
    .mon_acc(mon_acc0), .mon_count(mon_count0)
`endif
  );

  arith_select_pipe #(.WIDTH(W), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_s(in_s), .in_clr(in_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_carry(out_carry1), .out_zero(out_zero1)
`ifdef ARITH_SELECT_PIPE_MONITOR_EN
    , .mon_a(mon_a1), .mon_b(mon_b1), .mon_c(mon_c1), .mon_s(mon_s1),
    .mon_acc(mon_acc1), .mon_count(mon_count1)
`endif
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         carry;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int pop_count = 0;
  bit sb_off = 1'b0;
  bit hold0 = 1'b0, hold1 = 1'b0;
  logic [W-1:0] held0, held1;

  function automatic void cmp(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor for the wrapping instance: hold stability, then scoreboard pop on transfer.
  always @(negedge clk) begin
    if (reset || sb_off) begin
      hold0 = 1'b0;
    end else begin
      if (hold0 && out_valid0) cmp("hold0", out_data0, held0);
      hold0 = out_valid0 && !out_ready;
      held0 = out_data0;
      if (out_valid0 && out_ready) begin
        pop_count++;
        cmp("sb0_nonempty", (q0.size() > 0) ? 1 : 0, 1);
        if (q0.size() > 0) begin
          exp_t e;
          e = q0.pop_front();
          cmp("data0", out_data0, e.data);
          cmp("carry0", out_carry0, e.carry);
          cmp("zero0", out_zero0, (e.data == 8'd0) ? 1 : 0);
        end
      end
    end
  end

  // Monitor for the saturating instance.
  always @(negedge clk) begin
    if (reset || sb_off) begin
      hold1 = 1'b0;
    end else begin
      if (hold1 && out_valid1) cmp("hold1", out_data1, held1);
      hold1 = out_valid1 && !out_ready;
      held1 = out_data1;
      if (out_valid1 && out_ready) begin
        cmp("sb1_nonempty", (q1.size() > 0) ? 1 : 0, 1);
        if (q1.size() > 0) begin
          exp_t e;
          e = q1.pop_front();
          cmp("data1", out_data1, e.data);
          cmp("carry1", out_carry1, e.carry);
          cmp("zero1", out_zero1, (e.data == 8'd0) ? 1 : 0);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input int a, input int b, input int c,
                      input logic s, input logic clr,
                      input int d0, input logic c0, input int d1, input logic c1);
    int n;
    in_op = op; in_a = a[W-1:0]; in_b = b[W-1:0]; in_c = c[W-1:0];
    in_s = s; in_clr = clr; in_valid = 1'b1;
    q0.push_back('{data: d0[W-1:0], carry: c0});
    q1.push_back('{data: d1[W-1:0], carry: c1});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready0 && n < 200);
    cmp("accept", in_ready0, 1);
    @(posedge clk);
    #1;
    accepted++;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op = 2'b11; in_a = 8'hA5; in_b = 8'h5A; in_c = 8'h3C; in_s = 1'b1; in_clr = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmp("drain", q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    reset = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_out_valid", out_valid0, 0);
    cmp("rst_out_data", out_data0, 0);
    cmp("rst_out_zero", out_zero0, 1);
    cmp("rst_out_carry", out_carry0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp("rst_in_ready", in_ready0, 1);
    @(posedge clk);
    #1;

    // ADD with exact two-cycle latency
    send(2'b00, 200, 100, 0, 1'b0, 1'b0, 44, 1'b1, 255, 1'b1);
    idle();
    @(negedge clk);
    cmp("lat_s1", out_valid0, 0);
    @(negedge clk);
    cmp("lat_s2", out_valid0, 1);
    drain();

    // Directed vectors, back to back
    send(2'b01, 5, 0, 9, 1'b0, 1'b0, 252, 1'b1, 0, 1'b1);
    send(2'b10, 7, 0, 9, 1'b0, 1'b0, 7, 1'b0, 7, 1'b0);
    send(2'b10, 20, 0, 5, 1'b1, 1'b0, 15, 1'b0, 15, 1'b0);
    send(2'b10, 3, 0, 4, 1'b1, 1'b0, 255, 1'b1, 0, 1'b1);
    send(2'b00, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    send(2'b01, 9, 0, 9, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    send(2'b00, 255, 1, 0, 1'b0, 1'b0, 0, 1'b1, 255, 1'b1);
    idle();
    drain();

    // Accumulate stream, one result per cycle
    pc = pop_count;
    send(2'b11, 100, 0, 0, 1'b0, 1'b1, 100, 1'b0, 100, 1'b0);
    send(2'b11, 100, 0, 0, 1'b0, 1'b0, 200, 1'b0, 200, 1'b0);
    send(2'b11, 100, 0, 0, 1'b0, 1'b0, 44, 1'b1, 255, 1'b1);
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    cmp("acc_no_bubble", pop_count - pc, 3);
    drain();

    // Non-ACC clear resets the accumulator after its own result
    send(2'b00, 1, 2, 0, 1'b0, 1'b1, 3, 1'b0, 3, 1'b0);
    send(2'b11, 5, 0, 0, 1'b0, 1'b0, 5, 1'b0, 5, 1'b0);
    idle();
    drain();

    // Backpressure: three SUBs offered while output is stalled
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(2'b01, 50, 0, 10, 1'b0, 1'b0, 40, 1'b0, 40, 1'b0);
        send(2'b01, 30, 0, 31, 1'b0, 1'b0, 255, 1'b1, 0, 1'b1);
        send(2'b01, 7, 0, 0, 1'b0, 1'b0, 7, 1'b0, 7, 1'b0);
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        cmp("bp_in_ready", in_ready0, 0);
        cmp("bp_accepted", accepted, 2);
        cmp("bp_out_data", out_data0, 40);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(2'b11, 9, 0, 0, 1'b0, 1'b0, 14, 1'b0, 14, 1'b0);
    send(2'b00, 1, 1, 0, 1'b0, 1'b0, 2, 1'b0, 2, 1'b0);
    idle();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("mid_rst_valid0", out_valid0, 0);
    cmp("mid_rst_valid1", out_valid1, 0);
    cmp("mid_rst_data0", out_data0, 0);
    cmp("mid_rst_zero0", out_zero0, 1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(2'b11, 3, 0, 0, 1'b0, 1'b0, 3, 1'b0, 3, 1'b0);
    idle();
    drain();

`ifdef ARITH_SELECT_PIPE_MONITOR_EN
    cmp("mon_acc", mon_acc0, 3);
    @(negedge clk);
    reset = 1'b1;
    #1 cmp("mon_count_rst", mon_count0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    sb_off = 1'b1;
    in_op = 2'b00; in_a = 8'd0; in_b = 8'd0; in_clr = 1'b0;
    in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp("mon_count_wrap", mon_count0, 4464);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_select_pipe.md
Name: arith_select_pipe

Overview:
- Parametrised, pipelined successor to the add/subtract/select datapath.
- Accepts operand triples (a, b, c) plus a select bit and an opcode over a valid/ready handshake.
- Computes one of add, subtract, subtract-select or accumulate, with optional saturation.
- Returns the result with carry/zero flags two cycles later, under full backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- SATURATE, 0, 0 = results wrap modulo 2^WIDTH; 1 = unsigned clamp (overflow -> all ones, underflow -> 0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_op  input  2  opcode: 00 ADD, 01 SUB, 10 SEL, 11 ACC.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b (ADD).
- in_c  input  WIDTH  operand c (SUB/SEL subtrahend).
- in_s  input  1  select for SEL.
- in_clr  input  1  accumulator clear sideband.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  result.
- out_carry  output  1  ADD/ACC carry-out, SUB/SEL borrow, independent of SATURATE.
- out_zero  output  1  out_data == 0.

Behaviour:
- Reset (async, immediate): s1_valid=0, out_valid=0, out_data=0, out_carry=0, out_zero=1, acc=0, in_ready=1 after release. An in-flight transaction is discarded; no partial output appears.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Stage 1 registers op, a, b, c, s, clr when the input transfer occurs.
- Stage 2 computes and registers the result, flags and accumulator update.
- advance = !out_valid | out_ready; in_ready = !s1_valid | advance. No combinational path from in_valid to in_ready.
- Latency: 2 cycles from input transfer to out_valid. Throughput is 1 per cycle when out_ready is held high.
- Stall: while out_valid & !out_ready, out_data/out_carry/out_zero are held stable and stage 1 holds. Once stage 1 is also full, in_ready=0.
- Arithmetic (computed at WIDTH+1 bits):
  - ADD = a+b.
  - SUB = a-c.
  - SEL = s ? (a-c) : a. For s=0, carry=0.
  - ACC = acc+a (acc+ means the accumulator value before this transaction).
- Saturation (SATURATE=1): ADD/ACC overflow gives all ones; SUB/SEL borrow gives 0.
- Accumulator (WIDTH-bit register, updated only when the transaction moves into stage 2):
  - ACC, clr=0: acc <= result (saturated or wrapped per SATURATE), out_data = new acc.
  - ACC, clr=1: acc <= a, out_data = a, carry=0.
  - Non-ACC, clr=1: acc <= 0 after that op's result is computed.
  - Non-ACC, clr=0: acc unchanged.
- Back-to-back ACC transactions chain with no bubble: each uses the acc value written by its predecessor.
- Input fields are ignored when in_valid=0. Changing inputs while in_ready=0 has no effect.

Optional Feature:
- Macro: ARITH_SELECT_PIPE_MONITOR_EN.
- Defined, adds outputs:
  - mon_a, mon_b, mon_c (WIDTH each): stage-1 operand registers.
  - mon_s (1): stage-1 select register.
  - mon_acc (WIDTH): accumulator.
  - mon_count (16): output transfers since reset, wraps at 65535->0.
- Undefined: these ports and the counter do not exist. Core behaviour is identical in both cases.

Test Plan:
- WIDTH=8, SATURATE=0: ADD a=200,b=100 -> out_data=44, carry=1, zero=0, exactly 2 cycles after transfer.
- SATURATE=1: ADD 200+100 -> 255, carry=1. SUB a=5,c=9 -> 0, carry=1. SEL s=0 a=7 -> 7, carry=0.
- ACC stream a=100,100,100 (first with clr=1), out_ready=1 -> 100,200,44 (carry on third) with SATURATE=0; 100,200,255 with SATURATE=1; one result per cycle.
- Backpressure: out_ready=0 for 5 cycles while 3 SUB ops offered -> in_ready drops after 2 accepted, out_data stable. Releasing out_ready delivers all 3 in order with no loss or duplication.
- Assert reset mid-stream with both stages full -> out_valid=0, out_data=0, acc=0 immediately. After release the next ACC a=3 returns 3.
- With ARITH_SELECT_PIPE_MONITOR_EN: 70000 output transfers -> mon_count=4464. mon_acc tracks the accumulator each cycle.
